hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 56 +++++
 rtl/sat_counter.sv | 25 ++
 rtl/hazard_ctrl.sv | 123 ++++++++++++
 tb/tb_hazard_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM encoding, default sizing constants,
// the bundled control-output struct and the RUN-state priority decoder.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2
    } hz_state_t;

    localparam int REG_W_DEF    = 5;
    localparam int WAIT_MAX_DEF = 255;
    localparam int CNT_W_DEF    = 16;

    typedef struct packed {
        logic pc_wr;
        logic if_id_wr;
        logic if_id_flush;
        logic id_ex_flush;
        logic pipe_freeze;
    } hz_ctrl_t;

    // Memory stall: nothing advances, nothing is squashed.
    localparam hz_ctrl_t CTRL_FREEZE = '{pc_wr: 1'b0, if_id_wr: 1'b0, if_id_flush: 1'b0,
                                         id_ex_flush: 1'b0, pipe_freeze: 1'b1};

    // Held in reset: fetch blocked and both front-end registers squashed.
    localparam hz_ctrl_t CTRL_RESET  = '{pc_wr: 1'b0, if_id_wr: 1'b0, if_id_flush: 1'b1,
                                         id_ex_flush: 1'b1, pipe_freeze: 1'b0};

    // Priority decode for the RUN state: mem_busy > branch > load-use > jump.
    function automatic hz_ctrl_t run_ctrl(input logic mem_busy,
                                          input logic branch_taken,
                                          input logic load_use,
                                          input logic jump_id);
        hz_ctrl_t c;
        c = '{pc_wr: 1'b1, if_id_wr: 1'b1, if_id_flush: 1'b0,
              id_ex_flush: 1'b0, pipe_freeze: 1'b0};
        if (mem_busy) begin
            c = CTRL_FREEZE;
        end else if (branch_taken) begin
            c.if_id_flush = 1'b1;
            c.id_ex_flush = 1'b1;
        end else if (load_use) begin
            // Hold PC and IF/ID one cycle and bubble EX; the load then
            // leaves EX, so the hazard clears itself without extra state.
            c.pc_wr       = 1'b0;
            c.if_id_wr    = 1'b0;
            c.id_ex_flush = 1'b1;
        end else if (jump_id) begin
            c.if_id_flush = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; used for the pipeline
// performance counters.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = W'(1);

    // Count up on inc, stick at all-ones, clear has priority.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch/jump flushes, memory
// wait freezing with a timeout that parks the pipeline in HALT until reset.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_W    = REG_W_DEF,
    parameter int WAIT_MAX = WAIT_MAX_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             branch_taken,
    input  logic             jump_id,
    input  logic             mem_busy,
    output logic             PC_Wr,
    output logic             IF_ID_Wr,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             pipe_freeze,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Sized so the count can reach WAIT_MAX exactly and never wraps.
    localparam int              WAIT_W     = $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(WAIT_MAX);

    hz_state_t         state, next_state;
    logic [WAIT_W-1:0] wait_cnt, wait_next;
    hz_ctrl_t          ctrl;
    logic              load_use;

    // Load in EX writes a register the ID instruction reads ($0 never hazards).
    always_comb begin
        load_use = ex_mem_read && (ex_rt != '0) &&
                   ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    end

    // State and wait-count registers; synchronous reset discards any wait.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= wait_next;
        end
    end

    // Next-state, wait counter and control outputs from state and inputs.
    // NOTE: every output gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state  = state;
        wait_next   = wait_cnt;
        ctrl        = CTRL_FREEZE;
        timeout_err = 1'b0;

        unique case (state)
            ST_RUN: begin
                ctrl = run_ctrl(mem_busy, branch_taken, load_use, jump_id);
                if (mem_busy) begin
                    next_state = ST_WAIT;
                    wait_next  = WAIT_ONE;
                end
            end
            ST_WAIT: begin
                if (mem_busy) begin
                    if (wait_cnt == WAIT_LIMIT) begin
                        next_state = ST_HALT;
                    end else begin
                        wait_next = wait_cnt + WAIT_ONE;
                    end
                end else begin
                    // Release cycle behaves as RUN on the current inputs.
                    ctrl       = run_ctrl(1'b0, branch_taken, load_use, jump_id);
                    next_state = ST_RUN;
                    wait_next  = '0;
                end
            end
            ST_HALT: begin
                timeout_err = 1'b1;
            end
            default: begin
                next_state = ST_RUN;
                wait_next  = '0;
            end
        endcase

        if (reset) begin
            ctrl        = CTRL_RESET;
            timeout_err = 1'b0;
        end
    end

    assign PC_Wr       = ctrl.pc_wr;
    assign IF_ID_Wr    = ctrl.if_id_wr;
    assign IF_ID_Flush = ctrl.if_id_flush;
    assign ID_EX_Flush = ctrl.id_ex_flush;
    assign pipe_freeze = ctrl.pipe_freeze;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (~ctrl.pc_wr),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (ctrl.if_id_flush),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl (WAIT_MAX=4, CNT_W=4 so timeout and
// counter saturation are reachable in a few cycles).
module tb_hazard_ctrl;

    localparam int REG_W    = 5;
    localparam int WAIT_MAX = 4;
    localparam int CNT_W    = 4;

    // Expected control vectors {PC_Wr, IF_ID_Wr, IF_ID_Flush, ID_EX_Flush, pipe_freeze}
    localparam logic [4:0] C_NONE   = 5'b11000;
    localparam logic [4:0] C_LU     = 5'b00010;
    localparam logic [4:0] C_BRANCH = 5'b11110;
    localparam logic [4:0] C_JUMP   = 5'b11100;
    localparam logic [4:0] C_FREEZE = 5'b00001;
    localparam logic [4:0] C_RESET  = 5'b00110;

    logic             clk = 1'b0;
    logic             reset;
    logic [REG_W-1:0] id_rs, id_rt, ex_rt;
    logic             id_uses_rt, ex_mem_read, branch_taken, jump_id, mem_busy;
    logic             PC_Wr, IF_ID_Wr, IF_ID_Flush, ID_EX_Flush, pipe_freeze, timeout_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [4:0]       ctrl;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign ctrl = {PC_Wr, IF_ID_Wr, IF_ID_Flush, ID_EX_Flush, pipe_freeze};

    hazard_ctrl #(.REG_W(REG_W), .WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .ex_mem_read  (ex_mem_read),
        .ex_rt        (ex_rt),
        .branch_taken (branch_taken),
        .jump_id      (jump_id),
        .mem_busy     (mem_busy),
        .PC_Wr        (PC_Wr),
        .IF_ID_Wr     (IF_ID_Wr),
        .IF_ID_Flush  (IF_ID_Flush),
        .ID_EX_Flush  (ID_EX_Flush),
        .pipe_freeze  (pipe_freeze),
        .timeout_err  (timeout_err),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b0;
        ex_mem_read = 1'b0; ex_rt = 5'd3;
        branch_taken = 1'b0; jump_id = 1'b0; mem_busy = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic set_lu(input logic [REG_W-1:0] rt);
        ex_mem_read = 1'b1; ex_rt = rt; id_rs = 5'd8;
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1; mem_busy = 1'b1; jump_id = 1'b1;
        #1;
        n_checks++;
        if (ctrl !== C_RESET) begin n_fail++; $display("FAIL reset_ctrl: ctrl=%b expected=%b", ctrl, C_RESET); end
        tick(); tick();
        n_checks++;
        if (timeout_err !== 1'b0 || stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
            n_fail++; $display("FAIL reset_state: timeout=%b stall=%0d flush=%0d expected 0/0/0", timeout_err, stall_cnt, flush_cnt);
        end
        reset = 1'b0;
        idle();
        n_checks++;
        if (ctrl !== C_NONE) begin n_fail++; $display("FAIL reset_release: ctrl=%b expected=%b", ctrl, C_NONE); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_lu(5'd8);
        n_checks++;
        if (ctrl !== C_LU) begin n_fail++; $display("FAIL lu_stall: ctrl=%b expected=%b", ctrl, C_LU); end
        tick();
        idle();
        n_checks++;
        if (ctrl !== C_NONE) begin n_fail++; $display("FAIL lu_one_bubble: ctrl=%b expected=%b", ctrl, C_NONE); end
        tick();
        n_checks++;
        if (stall_cnt !== 4'd1) begin n_fail++; $display("FAIL lu_stall_cnt: got %0d expected 1", stall_cnt); end
        // rt-side match only counts when the ID instruction reads rt
        ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd4; id_rt = 5'd9; id_uses_rt = 1'b1;
        #1;
        n_checks++;
        if (ctrl !== C_LU) begin n_fail++; $display("FAIL lu_rt_match: ctrl=%b expected=%b", ctrl, C_LU); end
        id_uses_rt = 1'b0;
        #1;
        n_checks++;
        if (ctrl !== C_NONE) begin n_fail++; $display("FAIL lu_rt_unused: ctrl=%b expected=%b", ctrl, C_NONE); end
        // Register match without a load is not a hazard
        ex_mem_read = 1'b0; ex_rt = 5'd4;
        #1;
        n_checks++;
        if (ctrl !== C_NONE) begin n_fail++; $display("FAIL lu_no_load: ctrl=%b expected=%b", ctrl, C_NONE); end
    endtask

    task automatic test_ex_rt_zero();
        do_reset();
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
        #1;
        n_checks++;
        if (ctrl !== C_NONE) begin n_fail++; $display("FAIL rt_zero_ctrl: ctrl=%b expected=%b", ctrl, C_NONE); end
        tick();
        n_checks++;
        if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL rt_zero_stall_cnt: got %0d expected 0", stall_cnt); end
    endtask

    task automatic test_branch_priority();
        do_reset();
        set_lu(5'd8);
        jump_id = 1'b1; branch_taken = 1'b1;
        #1;
        n_checks++;
        if (ctrl !== C_BRANCH) begin n_fail++; $display("FAIL branch_prio: ctrl=%b expected=%b", ctrl, C_BRANCH); end
        tick();
        n_checks++;
        if (flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
            n_fail++; $display("FAIL branch_counts: flush=%0d stall=%0d expected 1/0", flush_cnt, stall_cnt);
        end
        // load-use outranks a jump
        branch_taken = 1'b0;
        #1;
        n_checks++;
        if (ctrl !== C_LU) begin n_fail++; $display("FAIL lu_over_jump: ctrl=%b expected=%b", ctrl, C_LU); end
        idle();
        jump_id = 1'b1;
        #1;
        n_checks++;
        if (ctrl !== C_JUMP) begin n_fail++; $display("FAIL jump_only: ctrl=%b expected=%b", ctrl, C_JUMP); end
        tick();
        n_checks++;
        if (flush_cnt !== 4'd2) begin n_fail++; $display("FAIL jump_flush_cnt: got %0d expected 2", flush_cnt); end
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_busy = 1'b1; branch_taken = 1'b1;
        #1;
        n_checks++;
        if (ctrl !== C_FREEZE) begin n_fail++; $display("FAIL busy_over_branch: ctrl=%b expected=%b", ctrl, C_FREEZE); end
        tick();
        n_checks++;
        if (ctrl !== C_FREEZE) begin n_fail++; $display("FAIL wait_frozen_1: ctrl=%b expected=%b", ctrl, C_FREEZE); end
        branch_taken = 1'b0;
        tick();
        n_checks++;
        if (ctrl !== C_FREEZE) begin n_fail++; $display("FAIL wait_frozen_2: ctrl=%b expected=%b", ctrl, C_FREEZE); end
        tick();
        mem_busy = 1'b0; jump_id = 1'b1;
        #1;
        n_checks++;
        if (ctrl !== C_JUMP) begin n_fail++; $display("FAIL wait_release_jump: ctrl=%b expected=%b", ctrl, C_JUMP); end
        tick();
        idle();
        n_checks++;
        if (stall_cnt !== 4'd3 || flush_cnt !== 4'd1 || ctrl !== C_NONE) begin
            n_fail++; $display("FAIL wait_after: stall=%0d flush=%0d ctrl=%b expected 3/1/%b", stall_cnt, flush_cnt, ctrl, C_NONE);
        end
    endtask

    task automatic test_timeout();
        // Busy for one cycle short of the limit: must release cleanly.
        do_reset();
        mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        mem_busy = 1'b0;
        #1;
        n_checks++;
        if (ctrl !== C_NONE) begin n_fail++; $display("FAIL near_limit_release: ctrl=%b expected=%b", ctrl, C_NONE); end
        tick();
        n_checks++;
        if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL near_limit_no_err: timeout=%b expected 0", timeout_err); end
        // Held busy: RUN cycle plus WAIT_MAX wait cycles, then HALT.
        mem_busy = 1'b1;
        tick();
        for (int i = 0; i < WAIT_MAX; i++) begin
            n_checks++;
            if (timeout_err !== 1'b0 || ctrl !== C_FREEZE) begin
                n_fail++; $display("FAIL wait_cycle_%0d: timeout=%b ctrl=%b expected 0/%b", i + 1, timeout_err, ctrl, C_FREEZE);
            end
            tick();
        end
        n_checks++;
        if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL halt_entry: timeout=%b expected 1", timeout_err); end
        mem_busy = 1'b0; branch_taken = 1'b1;
        tick(); tick();
        n_checks++;
        if (timeout_err !== 1'b1 || ctrl !== C_FREEZE) begin
            n_fail++; $display("FAIL halt_sticky: timeout=%b ctrl=%b expected 1/%b", timeout_err, ctrl, C_FREEZE);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (timeout_err !== 1'b0 || ctrl !== C_RESET) begin
            n_fail++; $display("FAIL halt_reset: timeout=%b ctrl=%b expected 0/%b", timeout_err, ctrl, C_RESET);
        end
        tick();
        reset = 1'b0;
        idle();
        n_checks++;
        if (timeout_err !== 1'b0 || ctrl !== C_NONE) begin
            n_fail++; $display("FAIL halt_exit: timeout=%b ctrl=%b expected 0/%b", timeout_err, ctrl, C_NONE);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            set_lu(5'd8);
            tick();
            idle();
            tick();
            if (i == 14) begin
                n_checks++;
                if (stall_cnt !== 4'd14) begin n_fail++; $display("FAIL stall_cnt_14: got %0d expected 14", stall_cnt); end
            end
        end
        n_checks++;
        if (stall_cnt !== 4'd15) begin n_fail++; $display("FAIL stall_cnt_sat: got %0d expected 15", stall_cnt); end
        for (int i = 0; i < 20; i++) begin
            jump_id = 1'b1;
            tick();
        end
        idle();
        n_checks++;
        if (flush_cnt !== 4'd15) begin n_fail++; $display("FAIL flush_cnt_sat: got %0d expected 15", flush_cnt); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        // A load-use condition held two cycles bubbles twice, no hidden state.
        set_lu(5'd8);
        tick();
        n_checks++;
        if (ctrl !== C_LU) begin n_fail++; $display("FAIL b2b_lu_second: ctrl=%b expected=%b", ctrl, C_LU); end
        tick();
        idle();
        n_checks++;
        if (stall_cnt !== 4'd2) begin n_fail++; $display("FAIL b2b_stall_cnt: got %0d expected 2", stall_cnt); end
        // WAIT release straight into a load-use hazard
        mem_busy = 1'b1;
        tick(); tick();
        mem_busy = 1'b0;
        set_lu(5'd8);
        n_checks++;
        if (ctrl !== C_LU) begin n_fail++; $display("FAIL release_into_lu: ctrl=%b expected=%b", ctrl, C_LU); end
        tick();
        idle();
        n_checks++;
        if (ctrl !== C_NONE || stall_cnt !== 4'd5) begin
            n_fail++; $display("FAIL release_after: ctrl=%b stall=%0d expected %b/5", ctrl, stall_cnt, C_NONE);
        end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_load_use();
        test_ex_rt_zero();
        test_branch_priority();
        test_mem_wait();
        test_timeout();
        test_saturation();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
